// File: rtl/ip_pkg.sv
// Constants shared by the IPv4 transmit scheduler and the encapsulator.
package ip_pkg;

  localparam int unsigned DEF_PAYLOAD_LEN = 262;
  localparam int unsigned DEF_TCPH_LEN    = 20;
  localparam int unsigned IPH_LEN         = 20;

  localparam logic [3:0] IPV4_VERSION   = 4'd4;
  localparam logic [3:0] IPV4_IHL       = 4'd5;
  localparam logic [7:0] IPV4_TTL       = 8'd64;
  localparam logic [7:0] IPV4_PROTO_TCP = 8'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_CSUM  = 2'd2,
    ST_OUT   = 2'd3
  } tx_state_e;

  // Width in bits of a TCP segment (header plus payload).
  function automatic int unsigned seg_width(input int unsigned payload_len,
                                            input int unsigned tcph_len);
    return (payload_len + tcph_len) * 8;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int unsigned pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[IDX_W'(pos)]) begin
        found                = 1'b1;
        idx                  = IDX_W'(pos);
        grant[IDX_W'(pos)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_tx_scheduler.sv
// Arbitrates TCP segment sources onto the shared IPv4 encapsulator and
// sequences its build/checksum phases before handing the datagram to the MAC.
module ip_tx_scheduler
  import ip_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned PAYLOAD_LEN = DEF_PAYLOAD_LEN,
  parameter  int unsigned TCPH_LEN    = DEF_TCPH_LEN,
  parameter  int unsigned CSUM_LAT    = 1,
  parameter  logic [15:0] IDENT_INIT  = 16'h0000,
  localparam int unsigned SEG_W       = seg_width(PAYLOAD_LEN, TCPH_LEN),
  localparam int unsigned SRC_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*SEG_W-1:0] req_seg,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [SEG_W-1:0]         enc_seg,
  output logic [15:0]              enc_ident,
  output logic                     enc_phase,
  output logic                     enc_en,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [SRC_W-1:0]         tx_src,
  output logic [31:0]              pkt_cnt
);

  localparam int unsigned CNT_W = $clog2(CSUM_LAT + 1);

  tx_state_e          state_q, state_d;
  logic [SRC_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   csum_cnt_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic [SRC_W-1:0]   arb_idx;
  logic               arb_found;
  logic               take_c;
  logic               accept_c;
  logic               csum_last_c;
  logic [SRC_W-1:0]   ptr_next_c;
  logic [SEG_W-1:0]   seg_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign seg_arr[g] = req_seg[g*SEG_W +: SEG_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  assign csum_last_c = (csum_cnt_q == CNT_W'(CSUM_LAT - 1));
  assign ptr_next_c  = (tx_src == SRC_W'(NUM_REQ - 1)) ? '0 : tx_src + SRC_W'(1);
  // Accept pulse is suppressed during reset so a source never loses a segment.
  assign req_ready   = (take_c && !rst) ? arb_grant : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    take_c   = 1'b0;
    accept_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          take_c  = 1'b1;
          state_d = ST_BUILD;
        end
      end
      ST_BUILD: state_d = ST_CSUM;
      ST_CSUM: begin
        if (csum_last_c) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (tx_ready) begin
          accept_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered encapsulator/MAC controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      csum_cnt_q <= '0;
      enc_seg    <= '0;
      enc_ident  <= IDENT_INIT;
      enc_phase  <= 1'b0;
      enc_en     <= 1'b0;
      tx_valid   <= 1'b0;
      tx_src     <= '0;
      pkt_cnt    <= '0;
    end else begin
      enc_en     <= (state_d == ST_BUILD) || (state_d == ST_CSUM);
      enc_phase  <= (state_d == ST_CSUM);
      tx_valid   <= (state_d == ST_OUT);
      csum_cnt_q <= (state_q == ST_CSUM) ? csum_cnt_q + CNT_W'(1) : '0;
      if (take_c) begin
        enc_seg <= seg_arr[arb_idx];
        tx_src  <= arb_idx;
      end
      // Identification advances only on MAC acceptance, keeping values consecutive.
      if (accept_c) begin
        pkt_cnt   <= pkt_cnt + 32'd1;
        enc_ident <= enc_ident + 16'd1;
        ptr_q     <= ptr_next_c;
      end
    end
  end

endmodule

// File: tb/tb_ip_tx_scheduler.sv
// Bench for ip_tx_scheduler: arbitration table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
module tb_ip_tx_scheduler;

  localparam int N     = 4;
  localparam int SW    = (262 + 20) * 8;
  localparam int LAT_A = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [SW-1:0]     seg_src [N];
  logic [N*SW-1:0]   req_seg;
  logic              tx_ready;

  logic [N-1:0]  req_ready_a, req_ready_b;
  logic [SW-1:0] enc_seg_a, enc_seg_b;
  logic [15:0]   enc_ident_a, enc_ident_b;
  logic          enc_phase_a, enc_phase_b;
  logic          enc_en_a, enc_en_b;
  logic          tx_valid_a, tx_valid_b;
  logic [1:0]    tx_src_a, tx_src_b;
  logic [31:0]   pkt_cnt_a, pkt_cnt_b;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_seg[g*SW +: SW] = seg_src[g];
  end

  always #5 clk = ~clk;

  ip_tx_scheduler #(.NUM_REQ(N)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_seg(req_seg),
    .req_ready(req_ready_a), .enc_seg(enc_seg_a), .enc_ident(enc_ident_a),
    .enc_phase(enc_phase_a), .enc_en(enc_en_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready), .tx_src(tx_src_a), .pkt_cnt(pkt_cnt_a)
  );

  ip_tx_scheduler #(.NUM_REQ(N), .CSUM_LAT(3), .IDENT_INIT(16'hFFFE)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_seg(req_seg),
    .req_ready(req_ready_b), .enc_seg(enc_seg_b), .enc_ident(enc_ident_b),
    .enc_phase(enc_phase_b), .enc_en(enc_en_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready), .tx_src(tx_src_b), .pkt_cnt(pkt_cnt_b)
  );

  // Reference model state (dut_a): one datagram in flight, aged in cycles since grant.
  bit            m_busy;
  int            m_age;
  int            m_src;
  logic [SW-1:0] m_seg;
  logic [15:0]   m_ident;
  logic [31:0]   m_cnt;
  int            m_ptr;
  bit [N-1:0]    pend;

  typedef struct {
    int         warm_src;
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } arb_vec_t;
  arb_vec_t vt [12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_seg(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got top32 %h low64 %h expected top32 %h low64 %h",
               name, got[SW-1 -: 32], got[63:0], exp[SW-1 -: 32], exp[63:0]);
    end
  endtask

  function automatic logic [SW-1:0] rnd_seg();
    logic [SW-1:0] s;
    s = '0;
    for (int w = 0; w < SW / 16; w++) s[w*16 +: 16] = 16'($urandom);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tx_ready  = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic m_reset();
    m_busy  = 1'b0;
    m_age   = 0;
    m_src   = 0;
    m_seg   = '0;
    m_ident = 16'h0000;
    m_cnt   = 32'd0;
    m_ptr   = 0;
  endtask

  // Push one datagram from source p through dut_a so the pointer lands on p+1.
  task automatic warm(input int p);
    int n;
    req_valid = N'(1) << p;
    tx_ready  = 1'b1;
    step();
    req_valid = '0;
    n = 0;
    while (!tx_valid_a && n < 10) begin
      step();
      n++;
    end
    chk("warm_tx_valid", 64'(tx_valid_a), 64'd1);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            n, ph, win, j;
    bit            e_tv, e_en, e_ph;
    logic [3:0]    exp_ready;
    logic [15:0]   eid;
    logic [SW-1:0] seg_a;

    vt[0]  = '{-1, 4'b0000, 4'b0000};
    vt[1]  = '{-1, 4'b0001, 4'b0001};
    vt[2]  = '{-1, 4'b1010, 4'b0010};
    vt[3]  = '{-1, 4'b1000, 4'b1000};
    vt[4]  = '{ 0, 4'b0001, 4'b0001};
    vt[5]  = '{ 0, 4'b1011, 4'b0010};
    vt[6]  = '{ 1, 4'b0011, 4'b0001};
    vt[7]  = '{ 2, 4'b0111, 4'b0001};
    vt[8]  = '{ 2, 4'b1111, 4'b1000};
    vt[9]  = '{ 3, 4'b1100, 4'b0100};
    vt[10] = '{ 1, 4'b1100, 4'b0100};
    vt[11] = '{ 3, 4'b1111, 4'b0001};

    rst = 1'b1;
    req_valid = '0;
    tx_ready = 1'b0;
    for (int i = 0; i < N; i++) seg_src[i] = '0;
    do_reset();

    // Reset values
    #1;
    chk("rst_req_ready", 64'(req_ready_a), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid_a), 64'd0);
    chk("rst_enc_en", 64'(enc_en_a), 64'd0);
    chk("rst_enc_phase", 64'(enc_phase_a), 64'd0);
    chk("rst_ident", 64'(enc_ident_a), 64'h0);
    chk("rst_tx_src", 64'(tx_src_a), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt_a), 64'd0);
    chk_seg("rst_enc_seg", enc_seg_a, '0);
    chk("rst_ident_b", 64'(enc_ident_b), 64'hFFFE);

    // Arbitration table: optional warm-up sets the pointer, then a request pattern.
    for (int v = 0; v < 12; v++) begin
      do_reset();
      if (vt[v].warm_src >= 0) warm(vt[v].warm_src);
      req_valid = vt[v].valid;
      tx_ready  = 1'b0;
      #1;
      chk($sformatf("arb_vec%0d", v), 64'(req_ready_a), 64'(vt[v].exp_ready));
    end

    // Single source latency
    do_reset();
    seg_a = rnd_seg();
    seg_src[0] = seg_a;
    req_valid = 4'b0001;
    tx_ready = 1'b1;
    #1;
    chk("single_grant", 64'(req_ready_a), 64'h1);
    step();
    req_valid = '0;
    #1;
    chk("single_build", 64'({tx_valid_a, enc_en_a, enc_phase_a}), 64'b010);
    chk("single_no_ready", 64'(req_ready_a), 64'd0);
    step();
    chk("single_csum", 64'({tx_valid_a, enc_en_a, enc_phase_a}), 64'b011);
    step();
    chk("single_out", 64'({tx_valid_a, enc_en_a}), 64'b10);
    chk_seg("single_seg", enc_seg_a, seg_a);
    chk("single_ident", 64'(enc_ident_a), 64'h0);
    chk("single_src", 64'(tx_src_a), 64'd0);
    step();
    chk("single_pkt_cnt", 64'(pkt_cnt_a), 64'd1);
    chk("single_done_valid", 64'(tx_valid_a), 64'd0);

    // Backpressure in OUT for 10 cycles
    seg_src[1] = rnd_seg();
    req_valid = 4'b0010;
    tx_ready = 1'b0;
    #1;
    chk("bp_grant", 64'(req_ready_a), 64'h2);
    step();
    req_valid = 4'b1101;
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_tx_valid", 64'(tx_valid_a), 64'd1);
      chk_seg("bp_seg", enc_seg_a, seg_src[1]);
      chk("bp_ident", 64'(enc_ident_a), 64'h1);
      chk("bp_src", 64'(tx_src_a), 64'd1);
      chk("bp_no_ready", 64'(req_ready_a), 64'd0);
      step();
    end
    tx_ready = 1'b1;
    step();
    chk("bp_pkt_cnt", 64'(pkt_cnt_a), 64'd2);
    chk("bp_ident_next", 64'(enc_ident_a), 64'h2);
    chk("bp_next_grant", 64'(req_ready_a), 64'h4);

    // Reset mid-CSUM after granting source 2
    do_reset();
    seg_src[2] = rnd_seg();
    req_valid = 4'b0100;
    #1;
    chk("rc_grant2", 64'(req_ready_a), 64'h4);
    step();
    step();
    chk("rc_in_csum", 64'(enc_phase_a), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rc_tx_valid", 64'(tx_valid_a), 64'd0);
    chk("rc_enc_en", 64'(enc_en_a), 64'd0);
    chk("rc_enc_phase", 64'(enc_phase_a), 64'd0);
    chk("rc_ident", 64'(enc_ident_a), 64'h0);
    chk("rc_tx_src", 64'(tx_src_a), 64'd0);
    chk_seg("rc_enc_seg", enc_seg_a, '0);
    req_valid = 4'b0101;
    #1;
    chk("rc_regrant0", 64'(req_ready_a), 64'h1);
    step();
    req_valid = 4'b0100;
    step();
    step();
    chk("rc_out_valid", 64'(tx_valid_a), 64'd1);
    chk("rc_out_src", 64'(tx_src_a), 64'd0);
    chk("rc_out_ident", 64'(enc_ident_a), 64'h0);

    // Reset coinciding with MAC acceptance
    rst = 1'b1;
    tx_ready = 1'b1;
    step();
    rst = 1'b0;
    tx_ready = 1'b0;
    chk("rh_pkt_cnt", 64'(pkt_cnt_a), 64'd0);
    chk("rh_ident", 64'(enc_ident_a), 64'h0);
    chk("rh_tx_valid", 64'(tx_valid_a), 64'd0);

    // All sources valid, MAC always ready: grants rotate every 4 cycles
    do_reset();
    for (int i = 0; i < N; i++) seg_src[i] = rnd_seg();
    req_valid = 4'b1111;
    tx_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      exp_ready = (c % 4 == 0) ? 4'(1 << ((c / 4) % 4)) : 4'b0000;
      chk($sformatf("rot_ready_c%0d", c), 64'(req_ready_a), 64'(exp_ready));
      if (c % 4 == 3) begin
        chk("rot_tx_valid", 64'(tx_valid_a), 64'd1);
        chk("rot_src", 64'(tx_src_a), 64'((c / 4) % 4));
        chk("rot_ident", 64'(enc_ident_a), 64'(c / 4));
        chk_seg("rot_seg", enc_seg_b == enc_seg_b ? enc_seg_a : enc_seg_a, seg_src[(c / 4) % 4]);
      end
      step();
    end

    // dut_b: ident wrap from FFFE and 3-cycle checksum phase
    do_reset();
    req_valid = 4'b0001;
    tx_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      seg_src[0] = rnd_seg();
      #1;
      chk("b_grant", 64'(req_ready_b), 64'h1);
      n = 0;
      ph = 0;
      do begin
        step();
        n++;
        if (enc_en_b && enc_phase_b) ph++;
      end while (!tx_valid_b && n < 12);
      eid = 16'hFFFE + 16'(d);
      chk("b_tx_valid_latency", 64'(n), 64'd5);
      chk("b_csum_cycles", 64'(ph), 64'd3);
      chk("b_ident", 64'(enc_ident_b), 64'(eid));
      chk_seg("b_seg", enc_seg_b, seg_src[0]);
      step();
    end
    chk("b_pkt_cnt", 64'(pkt_cnt_b), 64'd3);
    chk("b_ident_after", 64'(enc_ident_b), 64'h1);

    // Randomized run against the reference model
    do_reset();
    m_reset();
    pend = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          seg_src[i] = rnd_seg();
        end
      end
      req_valid = pend;
      tx_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 149) == 0);
      #1;
      win = -1;
      if (!m_busy && !rst) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (win < 0 && req_valid[j]) win = j;
        end
      end
      exp_ready = (win >= 0) ? 4'(1 << win) : 4'b0000;
      e_en = m_busy && m_age >= 1 && m_age <= 1 + LAT_A;
      e_ph = m_busy && m_age >= 2 && m_age <= 1 + LAT_A;
      e_tv = m_busy && m_age >= 2 + LAT_A;
      chk("rnd_req_ready", 64'(req_ready_a), 64'(exp_ready));
      chk("rnd_enc_en", 64'(enc_en_a), 64'(e_en));
      chk("rnd_enc_phase", 64'(enc_phase_a), 64'(e_ph));
      chk("rnd_tx_valid", 64'(tx_valid_a), 64'(e_tv));
      chk("rnd_tx_src", 64'(tx_src_a), 64'(m_src));
      chk("rnd_ident", 64'(enc_ident_a), 64'(m_ident));
      chk("rnd_pkt_cnt", 64'(pkt_cnt_a), 64'(m_cnt));
      chk_seg("rnd_seg", enc_seg_a, m_seg);
      if (rst) begin
        m_reset();
      end else if (!m_busy) begin
        if (win >= 0) begin
          m_busy = 1'b1;
          m_age = 1;
          m_src = win;
          m_seg = seg_src[win];
          pend[win] = 1'b0;
        end
      end else if (e_tv && tx_ready) begin
        m_busy = 1'b0;
        m_cnt = m_cnt + 32'd1;
        m_ident = m_ident + 16'd1;
        m_ptr = (m_src + 1) % N;
      end else begin
        m_age++;
      end
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_tx_scheduler.md
# ip_tx_scheduler

Sequences the shared IPv4 encapsulator and arbitrates it between several TCP segment sources (one per trading session). Grants one source at a time round-robin, latches its segment, assigns the IPv4 Identification value, and drives the encapsulator through its build and checksum-insert phases. Presents the finished datagram to the MAC side with a valid/ready handshake. Sits between the per-session TCP engines and the IP encapsulator/checksum pair.

## Interface
- NUM_REQ, 4: number of TCP segment sources (2..8)
- PAYLOAD_LEN, 262: TCP payload bytes per segment
- TCPH_LEN, 20: TCP header bytes
- CSUM_LAT, 1: cycles the encapsulator's checksum phase needs (1..4)
- IDENT_INIT, 16'h0000: Identification value after reset
- SEG_W, derived: (PAYLOAD_LEN+TCPH_LEN)*8

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  source i has a segment ready
- req_seg  in  NUM_REQ*SEG_W  flattened segments; source i at [i*SEG_W +: SEG_W]
- req_ready  out  NUM_REQ  one-hot accept pulse; segment i taken when req_valid[i]&req_ready[i]
- enc_seg  out  SEG_W  latched segment to encapsulator
- enc_ident  out  16  Identification field for current datagram
- enc_phase  out  1  0 = build header, 1 = insert checksum
- enc_en  out  1  encapsulator advance enable
- tx_valid  out  1  datagram at encapsulator output complete
- tx_ready  in  1  MAC side accepts datagram
- tx_src  out  clog2(NUM_REQ)  source index of current datagram
- pkt_cnt  out  32  datagrams accepted by MAC side since reset

## Operation
- States: IDLE, BUILD, CSUM, OUT.
- IDLE: if any req_valid, pick winner by round-robin starting at ptr; assert req_ready[winner] combinationally this cycle; register req_seg slice into enc_seg, tx_src=winner; -> BUILD. No req_valid: stay, req_ready=0.
- BUILD (1 cycle): enc_en=1, enc_phase=0; -> CSUM.
- CSUM (CSUM_LAT cycles, counted by csum_cnt): enc_en=1, enc_phase=1; after last cycle -> OUT.
- OUT: tx_valid=1, enc_en=0, enc_seg/enc_ident/tx_src held stable. On tx_valid&tx_ready: pkt_cnt+1, ident+1, ptr=tx_src+1 (mod NUM_REQ), -> IDLE.
- Round-robin: priority order ptr, ptr+1, ..., wrapping at NUM_REQ; ptr initial 0.
- ident wraps 16'hFFFF -> 16'h0000; increments only on MAC acceptance, so each accepted datagram carries a unique consecutive value.
- pkt_cnt wraps 2^32-1 -> 0.
- req_valid sampled only in IDLE; deassertion in other states has no effect; sources must hold req_valid and req_seg until accepted.
- tx_ready outside OUT is ignored.

## Timing
- Reset values: req_ready=0, enc_seg=0, enc_ident=IDENT_INIT, enc_phase=0, enc_en=0, tx_valid=0, tx_src=0, pkt_cnt=0, state=IDLE, ptr=0.
- Grant cycle t (IDLE) -> BUILD t+1 -> CSUM t+2..t+1+CSUM_LAT -> tx_valid first high t+2+CSUM_LAT.
- Minimum datagram period 3+CSUM_LAT cycles (tx_ready held high).
- tx_valid once high stays high, outputs stable, until accepted.
- rst in any state: next cycle all outputs at reset values, in-flight datagram discarded, ident not advanced.
- Simultaneous rst and tx_ready handshake: rst wins, pkt_cnt stays 0.

## Structure
- Package ip_pkg: state enum, SEG_W/length constants, IPv4 constants (VERSION=4, IHL=5, TTL=64, PROTOCOL=6) shared with the encapsulator.
- Sub-module rr_arbiter (NUM_REQ request vector + ptr -> one-hot grant + index); rest in ip_tx_scheduler.

## Test plan
- Single source: req_valid=4'b0001, seg=A, tx_ready=1 -> req_ready[0] one cycle, tx_valid at grant+3 (CSUM_LAT=1), enc_seg=A, enc_ident=0, pkt_cnt=1.
- All four valid continuously, tx_ready=1 -> grants 0,1,2,3,0 every 4 cycles; enc_ident 0,1,2,3,4.
- Backpressure: tx_ready=0 for 10 cycles in OUT -> tx_valid, enc_seg, enc_ident, tx_src stable; no new req_ready; accepted on first tx_ready=1.
- Wrap: IDENT_INIT=16'hFFFE, three datagrams -> idents FFFE, FFFF, 0000.
- Reset mid-CSUM after grant of source 2 -> outputs at reset values next cycle; following grant goes to source 0 if valid, ident=IDENT_INIT.
- CSUM_LAT=3 -> enc_phase=1 with enc_en=1 for exactly 3 cycles, tx_valid at grant+5.
